// File: rtl/keyboard_controller_pkg.sv
// Shared scan-code constants, key bit indices and decoder types for the keyboard front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package keyboard_controller_pkg;

  // Start, eight data bits, parity, stop.
  localparam int PS2_FRAME_BITS = 11;

  // Set-2 prefixes and special codes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_NUL   = 8'h00;
  localparam logic [7:0] SC_OVR   = 8'hFF;

  // Game keys (plain)
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;

  // Game keys (E0-prefixed arrows)
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Bit positions in the keys output
  localparam int KEY_FWD      = 0;
  localparam int KEY_BACK     = 1;
  localparam int KEY_TURN_L   = 2;
  localparam int KEY_TURN_R   = 3;
  localparam int KEY_STRAFE_L = 4;
  localparam int KEY_STRAFE_R = 5;
  localparam int KEY_FIRE     = 6;
  localparam int NUM_KEYS     = 7;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXTBRK
  } dec_state_t;

  // One flag per physical key; fwd/back have two aliases each so that
  // releasing one alias does not drop a bit still held by the other.
  typedef struct packed {
    logic fire;
    logic strafe_r;
    logic strafe_l;
    logic turn_r;
    logic turn_l;
    logic back_arrow;
    logic back_key;
    logic fwd_arrow;
    logic fwd_key;
  } key_src_t;

  // One-hot source mask for a scan code; all-zero for unmapped codes.
  function automatic key_src_t key_lookup(input logic [7:0] code, input logic ext);
    key_src_t m;
    m = '0;
    if (!ext) begin
      case (code)
        SC_W:     m.fwd_key  = 1'b1;
        SC_S:     m.back_key = 1'b1;
        SC_A:     m.strafe_l = 1'b1;
        SC_D:     m.strafe_r = 1'b1;
        SC_SPACE: m.fire     = 1'b1;
        default:  m = '0;
      endcase
    end else begin
      case (code)
        SC_UP:    m.fwd_arrow  = 1'b1;
        SC_DOWN:  m.back_arrow = 1'b1;
        SC_LEFT:  m.turn_l     = 1'b1;
        SC_RIGHT: m.turn_r     = 1'b1;
        default:  m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/keyboard_controller_ps2_rx.sv
// PS/2 receiver: synchronises and de-glitches the pins, shifts in 11-bit frames, checks parity/stop, drops stalled frames.
// Latency: rx_byte/byte_valid one cycle after the filtered clock's falling edge that carries the stop bit.
// Backpressure: none; byte_valid and frame_error are single-cycle pulses that must be consumed when seen.
module ps2_rx
  import keyboard_controller_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] PAR_BIT  = 4'(PS2_FRAME_BITS - 2);
  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, filt_clk_q;
  logic [FW-1:0] flt_cnt;
  logic          fall;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity_bit;
  logic [TW-1:0] to_cnt;
  logic          timeout;

  // Two-flop synchronisers on both pins; idle bus reads as 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  // Filtered clock follows the synced clock only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filt_clk   <= 1'b1;
      filt_clk_q <= 1'b1;
      flt_cnt    <= '0;
    end else begin
      filt_clk_q <= filt_clk;
      if (clk_s2 == filt_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s2;
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fall    = filt_clk_q & ~filt_clk;
  assign timeout = (bit_cnt != 4'd0) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Idle counter: cleared by every falling edge, saturates so it never wraps into a false timeout.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (fall) begin
      to_cnt <= '0;
    end else if ((bit_cnt != 4'd0) && (to_cnt != TW'(TIMEOUT_CYCLES))) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Bit sequencer: start, LSB-first data, odd parity, stop; result or error pulsed for one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt     <= 4'd0;
      shift       <= 8'h00;
      parity_bit  <= 1'b0;
      rx_byte     <= 8'h00;
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (timeout) begin
        frame_error <= 1'b1;
        bit_cnt     <= 4'd0;
      end else if (fall) begin
        if (bit_cnt == 4'd0) begin
          // A high start bit is line noise: ignore it quietly.
          if (!dat_s2) bit_cnt <= 4'd1;
        end else if (bit_cnt == PAR_BIT) begin
          parity_bit <= dat_s2;
          bit_cnt    <= LAST_BIT;
        end else if (bit_cnt == LAST_BIT) begin
          bit_cnt <= 4'd0;
          if (dat_s2 && (^{shift, parity_bit})) begin
            rx_byte    <= shift;
            byte_valid <= 1'b1;
          end else begin
            frame_error <= 1'b1;
          end
        end else begin
          shift   <= {dat_s2, shift[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/keyboard_controller.sv
// PS/2 keyboard front end: decodes set-2 make/break/extended codes into held-key levels for player_updater.
// Latency: scan_code/scan_valid one cycle after the accepting clock edge, keys one cycle after scan_valid.
// Backpressure: none; keys are levels sampled at will, scan_valid/frame_error are unacknowledged pulses.
module keyboard_controller
  import keyboard_controller_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ps2_clk,
  input  logic                ps2_dat,
  output logic [NUM_KEYS-1:0] keys,
  output logic [7:0]          scan_code,
  output logic                scan_valid,
  output logic                frame_error
);

  dec_state_t state, state_nxt;
  key_src_t   src, src_nxt;
  key_src_t   hit;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clock       (clock),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .rx_byte     (scan_code),
    .byte_valid  (scan_valid),
    .frame_error (frame_error)
  );

  // Decoder state and per-source key flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= DEC_IDLE;
      src   <= '0;
    end else begin
      state <= state_nxt;
      src   <= src_nxt;
    end
  end

  // Prefix tracking and make/break application, one step per received byte.
  always_comb begin
    state_nxt = state;
    src_nxt   = src;
    hit       = key_lookup(scan_code, (state == DEC_EXT) || (state == DEC_EXTBRK));
    if (scan_valid) begin
      if ((scan_code == SC_BAT) || (scan_code == SC_NUL) || (scan_code == SC_OVR)) begin
        // Keyboard reset or buffer overrun: whatever we thought was held is stale.
        src_nxt   = '0;
        state_nxt = DEC_IDLE;
      end else begin
        case (state)
          DEC_IDLE: begin
            if (scan_code == SC_EXT)      state_nxt = DEC_EXT;
            else if (scan_code == SC_BRK) state_nxt = DEC_BRK;
            else                          src_nxt   = key_src_t'(src | hit);
          end
          DEC_EXT: begin
            if (scan_code == SC_BRK)      state_nxt = DEC_EXTBRK;
            else if (scan_code == SC_EXT) state_nxt = DEC_EXT;
            else begin
              src_nxt   = key_src_t'(src | hit);
              state_nxt = DEC_IDLE;
            end
          end
          DEC_BRK, DEC_EXTBRK: begin
            src_nxt   = key_src_t'(src & ~hit);
            state_nxt = DEC_IDLE;
          end
          default: state_nxt = DEC_IDLE;
        endcase
      end
    end
  end

  // A game bit is held while any of its sources is held.
  always_comb begin
    keys               = '0;
    keys[KEY_FWD]      = src.fwd_key | src.fwd_arrow;
    keys[KEY_BACK]     = src.back_key | src.back_arrow;
    keys[KEY_TURN_L]   = src.turn_l;
    keys[KEY_TURN_R]   = src.turn_r;
    keys[KEY_STRAFE_L] = src.strafe_l;
    keys[KEY_STRAFE_R] = src.strafe_r;
    keys[KEY_FIRE]     = src.fire;
  end

endmodule

// File: tb/tb_keyboard_controller.sv
// Bench for keyboard_controller: PS/2 bus model, scan-code scoreboard, vector table and corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_keyboard_controller;

  // Bus half-period and idle timeout shortened so the whole run stays a few thousand cycles.
  localparam int HALF = 10;
  localparam int TMO  = 300;

  typedef struct {
    logic [7:0] code;
    logic       bad;
    logic [6:0] exp_keys;
    int         exp_err;
  } vec_t;

  logic       clock   = 1'b0;
  logic       reset   = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [6:0] keys;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_error;

  int         n_vec = 0;
  int         n_err = 0;
  int         err_seen = 0;
  int         sv_pulses = 0;
  logic       chk_next = 1'b0;
  logic [6:0] keys_at_valid = '0;
  logic [6:0] keys_after = '0;
  logic       valid_after = 1'b0;
  logic [7:0] exp_q[$];
  vec_t       vt[$];

  always #10 clock = ~clock;

  keyboard_controller #(
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .keys        (keys),
    .scan_code   (scan_code),
    .scan_valid  (scan_valid),
    .frame_error (frame_error)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock, sampled on the falling edge; also acts as the scan_code scoreboard.
  task automatic tick();
    logic [7:0] e;
    @(negedge clock);
    if (reset) begin
      if (chk_next) begin
        keys_after  = keys;
        valid_after = scan_valid;
        chk_next    = 1'b0;
      end
      if (frame_error) err_seen++;
      if (scan_valid) begin
        sv_pulses++;
        keys_at_valid = keys;
        chk_next      = 1'b1;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL scan_unexpected: got %02h, no byte expected", scan_code);
        end else begin
          e = exp_q.pop_front();
          cmp("scan_code", {24'h0, scan_code}, {24'h0, e});
        end
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Device-side PS/2 model: data changes while clock is high, host samples on the fall.
  task automatic send_frame(input logic [7:0] code, input logic bad_par, input int nbits,
                            input logic glitch);
    logic [10:0] f;
    f = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    if ((nbits == 11) && !bad_par) exp_q.push_back(code);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      if (glitch && (i == 3)) begin
        wait_cycles(3); ps2_clk = 1'b0; wait_cycles(2); ps2_clk = 1'b1; wait_cycles(HALF - 5);
      end else begin
        wait_cycles(HALF);
      end
      ps2_clk = 1'b0;
      if (glitch && (i == 6)) begin
        wait_cycles(3); ps2_clk = 1'b1; wait_cycles(2); ps2_clk = 1'b0; wait_cycles(HALF - 5);
      end else begin
        wait_cycles(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    wait_cycles(3 * HALF);
  endtask

  initial begin
    int e0;
    int p0;

    // Make/break sequences with the key state expected after each byte.
    vt.push_back('{8'hF0, 1'b0, 7'h01, 0});
    vt.push_back('{8'h1D, 1'b0, 7'h00, 0});
    vt.push_back('{8'hE0, 1'b0, 7'h00, 0});
    vt.push_back('{8'h75, 1'b0, 7'h01, 0});   // up arrow
    vt.push_back('{8'h1D, 1'b0, 7'h01, 0});   // W as well
    vt.push_back('{8'hE0, 1'b0, 7'h01, 0});
    vt.push_back('{8'hF0, 1'b0, 7'h01, 0});
    vt.push_back('{8'h75, 1'b0, 7'h01, 0});   // up released, W still held
    vt.push_back('{8'hF0, 1'b0, 7'h01, 0});
    vt.push_back('{8'h1D, 1'b0, 7'h00, 0});
    vt.push_back('{8'hE0, 1'b0, 7'h00, 0});
    vt.push_back('{8'h6B, 1'b0, 7'h04, 0});   // left arrow is turn_l, bit 2
    vt.push_back('{8'hE0, 1'b0, 7'h04, 0});
    vt.push_back('{8'hF0, 1'b0, 7'h04, 0});
    vt.push_back('{8'h6B, 1'b0, 7'h00, 0});
    vt.push_back('{8'h1D, 1'b1, 7'h00, 1});   // bad parity
    vt.push_back('{8'h29, 1'b0, 7'h40, 0});
    vt.push_back('{8'h75, 1'b0, 7'h40, 0});   // keypad 8: unmapped
    vt.push_back('{8'h1B, 1'b0, 7'h42, 0});
    vt.push_back('{8'hE0, 1'b0, 7'h42, 0});
    vt.push_back('{8'h72, 1'b0, 7'h42, 0});
    vt.push_back('{8'hF0, 1'b0, 7'h42, 0});
    vt.push_back('{8'h1B, 1'b0, 7'h42, 0});   // S released, down still held
    vt.push_back('{8'hE0, 1'b0, 7'h42, 0});
    vt.push_back('{8'hF0, 1'b0, 7'h42, 0});
    vt.push_back('{8'h72, 1'b0, 7'h40, 0});
    vt.push_back('{8'hE0, 1'b0, 7'h40, 0});
    vt.push_back('{8'h74, 1'b0, 7'h48, 0});
    vt.push_back('{8'hE0, 1'b0, 7'h48, 0});
    vt.push_back('{8'h74, 1'b0, 7'h48, 0});   // typematic repeat
    vt.push_back('{8'hE0, 1'b0, 7'h48, 0});
    vt.push_back('{8'hF0, 1'b0, 7'h48, 0});
    vt.push_back('{8'h74, 1'b0, 7'h40, 0});
    vt.push_back('{8'h1C, 1'b0, 7'h50, 0});
    vt.push_back('{8'h23, 1'b0, 7'h70, 0});
    vt.push_back('{8'hAA, 1'b0, 7'h00, 0});   // BAT clears everything
    vt.push_back('{8'hF0, 1'b0, 7'h00, 0});
    vt.push_back('{8'h23, 1'b0, 7'h00, 0});
    vt.push_back('{8'h1D, 1'b0, 7'h01, 0});
    vt.push_back('{8'hE0, 1'b0, 7'h01, 0});
    vt.push_back('{8'hFF, 1'b0, 7'h00, 0});   // overrun from the EXT state
    vt.push_back('{8'h1D, 1'b0, 7'h01, 0});   // decoded as plain W, so back in IDLE
    vt.push_back('{8'h00, 1'b0, 7'h00, 0});
    vt.push_back('{8'hE0, 1'b0, 7'h00, 0});
    vt.push_back('{8'hE1, 1'b0, 7'h00, 0});   // pause prefix drops the E0
    vt.push_back('{8'h1D, 1'b0, 7'h01, 0});
    vt.push_back('{8'hF0, 1'b0, 7'h01, 0});
    vt.push_back('{8'h1D, 1'b0, 7'h00, 0});

    // Reset state
    #5;
    cmp("reset_keys", {25'h0, keys}, 32'h0);
    cmp("reset_scan_code", {24'h0, scan_code}, 32'h0);
    cmp("reset_scan_valid", {31'h0, scan_valid}, 32'h0);
    cmp("reset_frame_error", {31'h0, frame_error}, 32'h0);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    wait_cycles(5);

    // Single W frame: one pulse, keys follow exactly one cycle after scan_valid.
    p0 = sv_pulses;
    send_frame(8'h1D, 1'b0, 11, 1'b0);
    cmp("t1_pulses", sv_pulses - p0, 1);
    cmp("t1_keys_with_valid", {25'h0, keys_at_valid}, 32'h00);
    cmp("t1_keys_next", {25'h0, keys_after}, 32'h01);
    cmp("t1_valid_next", {31'h0, valid_after}, 32'h0);
    cmp("t1_scan_code", {24'h0, scan_code}, 32'h1D);

    // Vector table
    foreach (vt[i]) begin
      e0 = err_seen;
      send_frame(vt[i].code, vt[i].bad, 11, 1'b0);
      cmp($sformatf("vec%0d_keys", i), {25'h0, keys}, {25'h0, vt[i].exp_keys});
      cmp($sformatf("vec%0d_err", i), err_seen - e0, vt[i].exp_err);
      cmp($sformatf("vec%0d_drained", i), exp_q.size(), 0);
    end

    // Stalled frame: five bits then silence past the timeout.
    e0 = err_seen;
    p0 = sv_pulses;
    send_frame(8'h1D, 1'b0, 5, 1'b0);
    wait_cycles(TMO + 40);
    cmp("t4_timeout_err", err_seen - e0, 1);
    cmp("t4_no_scan", sv_pulses - p0, 0);
    send_frame(8'h23, 1'b0, 11, 1'b0);
    cmp("t4_keys", {25'h0, keys}, 32'h20);

    // Short glitches on the PS/2 clock must not add or lose bits.
    e0 = err_seen;
    send_frame(8'h29, 1'b0, 11, 1'b1);
    cmp("t6_glitch_keys", {25'h0, keys}, 32'h60);
    cmp("t6_glitch_err", err_seen - e0, 0);

    // Reset in the middle of a frame.
    send_frame(8'h1C, 1'b0, 6, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    cmp("t6_rst_keys", {25'h0, keys}, 32'h0);
    cmp("t6_rst_scan_code", {24'h0, scan_code}, 32'h0);
    cmp("t6_rst_scan_valid", {31'h0, scan_valid}, 32'h0);
    cmp("t6_rst_frame_error", {31'h0, frame_error}, 32'h0);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    wait_cycles(5);
    e0 = err_seen;
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    cmp("t6_after_rst_keys", {25'h0, keys}, 32'h10);
    cmp("t6_after_rst_err", err_seen - e0, 0);

    cmp("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
